// File: rtl/uid_auth_if.sv
// Command/response bundle between the frame parser and the UID authorisation table.
interface uid_auth_if #(
  parameter int UID_MAX = 8
);
  localparam int IDX_W = $clog2(UID_MAX);
  localparam int CNT_W = $clog2(UID_MAX + 1);

  logic [7:0]       cmd;
  logic             valid;
  logic [127:0]     uid_bytes_flat;
  logic [7:0]       uid_len;
  logic             ready;
  logic             done;
  logic [2:0]       status;
  logic [IDX_W-1:0] match_idx;
  logic [CNT_W-1:0] uid_count;

  modport master (
    output cmd, valid, uid_bytes_flat, uid_len,
    input  ready, done, status, match_idx, uid_count
  );

  modport slave (
    input  cmd, valid, uid_bytes_flat, uid_len,
    output ready, done, status, match_idx, uid_count
  );
endinterface

// File: rtl/uid_auth_table.sv
// UID table with check/add/delete/clear; capture cycle, then UID_MAX-cycle scan (or none), then one RESP cycle.
// ready is high only while idle with nothing captured; valid while busy is dropped, not queued.
module uid_auth_table #(
  parameter int UID_MAX     = 8,
  parameter int UID_LEN_MAX = 10
) (
  input logic     clk,
  input logic     rst,
  uid_auth_if.slave bus
);
  localparam int IDX_W = $clog2(UID_MAX);
  localparam int CNT_W = $clog2(UID_MAX + 1);
  localparam int DW    = UID_LEN_MAX * 8;

  localparam logic [7:0] CMD_CHECK = 8'h10;
  localparam logic [7:0] CMD_ADD   = 8'h11;
  localparam logic [7:0] CMD_DEL   = 8'h12;
  localparam logic [7:0] CMD_CLEAR = 8'h13;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND = 3'd1;
  localparam logic [2:0] ST_DUP       = 3'd2;
  localparam logic [2:0] ST_FULL      = 3'd3;
  localparam logic [2:0] ST_BAD_LEN   = 3'd4;
  localparam logic [2:0] ST_BAD_CMD   = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, state_nxt;

  logic             go;
  logic [7:0]       cap_cmd, cap_len;
  logic [DW-1:0]    cap_dat, in_masked;
  logic [DW-1:0]    tbl_dat [UID_MAX];
  logic [7:0]       tbl_len [UID_MAX];
  logic [UID_MAX-1:0] tbl_vld;
  logic [IDX_W-1:0] idx, hit_idx, free_idx, hit_sel, free_sel;
  logic             hit_found, free_found, cur_hit, cur_free, hit_any, free_any;
  logic [2:0]       status_q;
  logic [IDX_W-1:0] match_idx_q;
  logic [CNT_W-1:0] count_q;
  logic             ready, done, accept, len_ok, is_scan_cmd, last, add_wr;
  logic             unused_bits;

  assign unused_bits = ^bus.uid_bytes_flat;

  // Bytes past uid_len are zeroed so a full-width compare equals a prefix compare.
  always_comb begin
    in_masked = '0;
    for (int k = 0; k < UID_LEN_MAX; k++)
      if (k < int'(bus.uid_len)) in_masked[8*k +: 8] = bus.uid_bytes_flat[8*k +: 8];
  end

  assign len_ok      = (cap_len != 8'd0) && (cap_len <= 8'(UID_LEN_MAX));
  assign is_scan_cmd = cap_cmd inside {CMD_CHECK, CMD_ADD, CMD_DEL};
  assign last        = (idx == IDX_W'(UID_MAX - 1));
  assign cur_hit     = tbl_vld[idx] && (tbl_len[idx] == cap_len) && (tbl_dat[idx] == cap_dat);
  assign cur_free    = !tbl_vld[idx];
  assign hit_any     = hit_found || cur_hit;
  assign free_any    = free_found || cur_free;
  assign hit_sel     = hit_found ? hit_idx : idx;
  assign free_sel    = free_found ? free_idx : idx;
  assign add_wr      = (state == SCAN) && last && (cap_cmd == CMD_ADD) && !hit_any && free_any;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready  = !go;
        accept = bus.valid && !go;
        if (go) state_nxt = (is_scan_cmd && len_ok) ? SCAN : RESP;
      end
      SCAN: if (last) state_nxt = RESP;
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go          <= 1'b0;
      cap_cmd     <= '0;
      cap_len     <= '0;
      cap_dat     <= '0;
      tbl_vld     <= '0;
      idx         <= '0;
      hit_idx     <= '0;
      free_idx    <= '0;
      hit_found   <= 1'b0;
      free_found  <= 1'b0;
      status_q    <= ST_OK;
      match_idx_q <= '0;
      count_q     <= '0;
    end else begin
      go <= accept;
      if (accept) begin
        cap_cmd <= bus.cmd;
        cap_len <= bus.uid_len;
        cap_dat <= in_masked;
      end
      if (state == IDLE && go) begin
        idx        <= '0;
        hit_found  <= 1'b0;
        free_found <= 1'b0;
        if (!(is_scan_cmd && len_ok)) begin
          if (cap_cmd == CMD_CLEAR) begin
            tbl_vld     <= '0;
            count_q     <= '0;
            status_q    <= ST_OK;
            match_idx_q <= '0;
          end else if (is_scan_cmd) status_q <= ST_BAD_LEN;
          else                      status_q <= ST_BAD_CMD;
        end
      end
      if (state == SCAN) begin
        idx        <= idx + 1'b1;
        hit_found  <= hit_any;
        free_found <= free_any;
        hit_idx    <= hit_sel;
        free_idx   <= free_sel;
        // All table/status updates land on the edge entering RESP.
        if (last) begin
          case (cap_cmd)
            CMD_CHECK: begin
              status_q <= hit_any ? ST_OK : ST_NOT_FOUND;
              if (hit_any) match_idx_q <= hit_sel;
            end
            CMD_ADD: begin
              if (hit_any) begin
                status_q    <= ST_DUP;
                match_idx_q <= hit_sel;
              end else if (free_any) begin
                status_q          <= ST_OK;
                match_idx_q       <= free_sel;
                tbl_vld[free_sel] <= 1'b1;
                count_q           <= count_q + CNT_W'(1);
              end else status_q <= ST_FULL;
            end
            CMD_DEL: begin
              if (hit_any) begin
                status_q         <= ST_OK;
                match_idx_q      <= hit_sel;
                tbl_vld[hit_sel] <= 1'b0;
                count_q          <= count_q - CNT_W'(1);
              end else status_q <= ST_NOT_FOUND;
            end
            default: status_q <= ST_BAD_CMD;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && add_wr) begin
      tbl_dat[free_sel] <= cap_dat;
      tbl_len[free_sel] <= cap_len;
    end
  end

  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.status    = status_q;
  assign bus.match_idx = match_idx_q;
  assign bus.uid_count = count_q;
endmodule

// File: doc/uid_auth_table.md
# uid_auth_table

Parametrised UID authorisation table, successor to the fixed 4-entry/4-byte checker. It stores up to UID_MAX variable-length UIDs with per-entry valid bits and supports check, add, delete and clear commands. Each command runs a sequential one-entry-per-cycle scan behind a valid/ready handshake and reports a single-cycle result. It sits between the frame parser (cmd, UID bytes, length) and the response/LED logic.

## Interface

- UID_MAX, 8: number of table entries (≥2).
- UID_LEN_MAX, 10: maximum UID length in bytes (1..16).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd  in  8  0x10 check, 0x11 add, 0x12 delete, 0x13 clear; any other value is BAD_CMD.
- valid  in  1  command strobe; accepted on a rising edge where valid && ready.
- uid_bytes_flat  in  128  UID bytes; byte k is bits [8k+7:8k].
- uid_len  in  8  received UID length in bytes.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle result pulse; high only in RESP.
- status  out  3  0 OK, 1 NOT_FOUND, 2 DUPLICATE, 3 FULL, 4 BAD_LEN, 5 BAD_CMD.
- match_idx  out  $clog2(UID_MAX)  entry index hit, written or freed.
- uid_count  out  $clog2(UID_MAX+1)  number of valid entries.

## Operation

- Each entry holds UID_LEN_MAX data bytes, a length and a valid bit. On write, bytes at index ≥ uid_len are stored as zero.
- Match condition: entry valid, stored length == uid_len, and bytes 0..uid_len-1 equal.
- All inputs are captured into internal registers at accept. Later input changes have no effect on the running command.
- FSM states are IDLE, SCAN and RESP.
  - IDLE→SCAN: accepted check, add or delete with 1 ≤ uid_len ≤ UID_LEN_MAX.
  - IDLE→RESP: clear, BAD_LEN (uid_len 0 or > UID_LEN_MAX on check/add/delete), or BAD_CMD.
  - SCAN visits entries 0..UID_MAX-1, one per cycle, then goes to RESP.
  - RESP→IDLE always.
- Scan tracks the lowest matching index and the lowest free (invalid) index.
- Check: a match gives OK with match_idx = lowest match; otherwise NOT_FOUND. The table is unchanged.
- Add, in priority order:
  - A match gives DUPLICATE, with match_idx = the matching entry.
  - Otherwise, a free slot gives OK: write into the lowest free slot and set match_idx to it.
  - Otherwise FULL.
- Delete: a match clears that entry's valid bit and gives OK with match_idx set; otherwise NOT_FOUND.
- Clear: all valid bits cleared, status OK, match_idx 0.
- BAD_LEN and BAD_CMD leave the table unchanged. match_idx holds its previous value.
- Table writes, valid-bit changes and the uid_count update happen on the edge entering RESP. status, match_idx and uid_count are therefore consistent while done is high.
- uid_count never exceeds UID_MAX and never underflows.

## Timing

- Reset values: state IDLE, ready 1, done 0, status 0, match_idx 0, uid_count 0, all valid bits 0. Stored data bytes are don't-care.
- Reset mid-operation aborts the command. No partial write survives, and done does not pulse.
- Scanned command accepted at edge E0:
  - SCAN during cycles E0+1..E0+UID_MAX.
  - done high for exactly the cycle after edge E0+UID_MAX+1.
  - ready high again from edge E0+UID_MAX+2.
- Clear, BAD_LEN or BAD_CMD accepted at E0: done high for the cycle after E0+1, ready high from E0+2.
- valid while ready is low is ignored, not queued.
- status and match_idx hold their RESP values until the next RESP.
- Back-to-back: a command presented when ready rises is accepted on that edge. Sustained throughput is one scanned command per UID_MAX+2 cycles.

## Test plan

All scenarios use UID_MAX=4, UID_LEN_MAX=10.
- Reset, then add 4-byte DE AD BE EF → done exactly 6 cycles after accept; status 0, match_idx 0, uid_count 1. Repeat the same add → status 2, match_idx 0, uid_count 1.
- Add 7-byte 01..07, then check 4-byte 01 02 03 04 → status 1. Check 7-byte 01..07 → status 0, match_idx 1.
- Fill to 4 entries, add a new UID → status 3, count 4. Delete the UID in entry 1 → status 0, match_idx 1, count 3. Add the new UID → status 0, match_idx 1, count 4.
- Check with uid_len 0, then with uid_len 11 → status 4, done 2 cycles after accept, table unchanged. cmd 0x55 → status 5.
- With 3 entries stored: clear → status 0, count 0. Then check any stored UID → status 1.
- Assert rst 2 cycles into an add scan → no done pulse, ready 1 next cycle, count 0, and a later check of that UID → status 1. Pulse valid during SCAN with another add → ignored, count unchanged by it.
